// File: rtl/modulo_desmapeamento_mux8_1.sv
// modulo_desmapeamento_mux8_1
//   Demapping stage that reverses the 8-to-5 mux mapping. It buffers 5-bit
//   mapped codes (original bits e[7:3]) in a small FIFO and emits rebuilt
//   8-bit words. The dropped bits [2:0] are filled with a constant.
//
// Parameters:
//   DEPTH  FIFO entries (power of 2, >= 2)
//   PTR_W  log2(DEPTH)
//   FILL   constant for reconstructed bits [2:0] (3'b100 = midpoint)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   in_mapeado    mapped code, in_mapeado[4] corresponds to e[7]
//   in_valid      in_mapeado holds a code
//   in_ready      block can accept a code this cycle
//   out_e         reconstructed word at FIFO head (8'h00 when empty)
//   out_valid     out_e is valid
//   out_ready     consumer accepts out_e this cycle
//   count         number of stored entries, 0..DEPTH
//   overflow_err  sticky: code offered while full (cleared by reset only)
module modulo_desmapeamento_mux8_1 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter logic [2:0]  FILL  = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       in_mapeado,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [PTR_W:0]   cnt_next;
  logic             ovf;
  logic             push;
  logic             pop;

  // Status comes only from the stored count, so a pop while full cannot
  // open in_ready in the same cycle.
  always_comb begin
    in_ready  = (cnt != FULL_CNT);
    out_valid = (cnt != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = cnt + (PTR_W + 1)'(1);
      2'b01:   cnt_next = cnt - (PTR_W + 1)'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      // DEPTH is a power of 2, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt_next;
      if (in_valid && !in_ready) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: its contents are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_mapeado;
  end

  always_comb begin
    out_e = 8'h00;
    if (out_valid) out_e = {mem[rd_ptr], FILL};
  end

  assign count        = cnt;
  assign overflow_err = ovf;

endmodule

// File: tb/tb_modulo_desmapeamento_mux8_1.sv
module tb_modulo_desmapeamento_mux8_1;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] in_mapeado = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, ovf_a;
  logic [7:0] out_e_a;
  logic [2:0] count_a;
  logic       in_ready_b, out_valid_b, ovf_b;
  logic [7:0] out_e_b;
  logic [2:0] count_b;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of accepted codes plus a sticky flag.
  logic [4:0] q[$];
  logic       ovf_m = 1'b0;

  always #5 clk = ~clk;

  modulo_desmapeamento_mux8_1 #(.DEPTH(4), .PTR_W(2), .FILL(3'b000)) dut_a (
    .clk(clk), .reset(reset), .in_mapeado(in_mapeado), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_e(out_e_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .count(count_a), .overflow_err(ovf_a)
  );

  modulo_desmapeamento_mux8_1 #(.DEPTH(4), .PTR_W(2), .FILL(3'b100)) dut_b (
    .clk(clk), .reset(reset), .in_mapeado(in_mapeado), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_e(out_e_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .count(count_b), .overflow_err(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      ovf_m <= 1'b0;
    end else begin
      ovf_m <= ovf_m | (in_valid && q.size() == DEPTH);
      if (q.size() != 0 && out_ready) begin
        if (in_valid && q.size() != DEPTH) q.push_back(in_mapeado);
        void'(q.pop_front());
      end else if (in_valid && q.size() != DEPTH) begin
        q.push_back(in_mapeado);
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    chk("m_count_a", 32'(count_a), 32'(q.size()));
    chk("m_count_b", 32'(count_b), 32'(q.size()));
    chk("m_in_ready_a", 32'(in_ready_a), 32'(q.size() != DEPTH));
    chk("m_in_ready_b", 32'(in_ready_b), 32'(q.size() != DEPTH));
    chk("m_out_valid_a", 32'(out_valid_a), 32'(q.size() != 0));
    chk("m_out_valid_b", 32'(out_valid_b), 32'(q.size() != 0));
    chk("m_out_e_a", 32'(out_e_a), (q.size() != 0) ? 32'({q[0], 3'b000}) : 32'h0);
    chk("m_out_e_b", 32'(out_e_b), (q.size() != 0) ? 32'({q[0], 3'b100}) : 32'h0);
    chk("m_ovf_a", 32'(ovf_a), 32'(ovf_m));
    chk("m_ovf_b", 32'(ovf_b), 32'(ovf_m));
  end

  // Drive inputs at a falling edge, then let one rising edge pass.
  task automatic cyc(input logic v, input logic [4:0] d, input logic r);
    in_valid   = v;
    in_mapeado = d;
    out_ready  = r;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 32'h1);
    chk("rst_out_valid", 32'(out_valid_a), 32'h0);
    chk("rst_out_e", 32'(out_e_a), 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_ovf", 32'(ovf_a), 32'h0);
    reset = 1'b0;

    // Single push, one-cycle latency
    chk("t1_valid_push_cycle", 32'(out_valid_a), 32'h0);
    cyc(1'b1, 5'b10110, 1'b1);
    chk("t1_out_e", 32'(out_e_a), 32'hB0);
    chk("t1_valid", 32'(out_valid_a), 32'h1);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t1_empty_valid", 32'(out_valid_a), 32'h0);
    chk("t1_empty_count", 32'(count_a), 32'h0);

    // Midpoint fill
    cyc(1'b1, 5'b11111, 1'b0);
    chk("t2_fill_fc", 32'(out_e_b), 32'hFC);
    chk("t2_zero_fill_f8", 32'(out_e_a), 32'hF8);
    cyc(1'b0, 5'd0, 1'b1);
    cyc(1'b1, 5'b00000, 1'b0);
    chk("t2_fill_04", 32'(out_e_b), 32'h04);
    cyc(1'b0, 5'd0, 1'b1);

    // Fill to full, then overflow attempt
    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'(i), 1'b0);
    chk("t3_count_full", 32'(count_a), 32'h4);
    chk("t3_in_ready_full", 32'(in_ready_a), 32'h0);
    chk("t3_ovf_before", 32'(ovf_a), 32'h0);
    cyc(1'b1, 5'd5, 1'b0);
    chk("t3_ovf_set", 32'(ovf_a), 32'h1);
    chk("t3_count_stays", 32'(count_a), 32'h4);
    chk("t3_head_hold", 32'(out_e_a), 32'h08);

    // Full with push and pop together: only the pop happens
    cyc(1'b1, 5'd5, 1'b1);
    chk("t4_count3", 32'(count_a), 32'h3);
    chk("t4_in_ready", 32'(in_ready_a), 32'h1);
    chk("t4_head", 32'(out_e_a), 32'h10);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t4_head2", 32'(out_e_a), 32'h18);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t4_head3", 32'(out_e_a), 32'h20);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t4_drained_valid", 32'(out_valid_a), 32'h0);
    chk("t4_drained_e", 32'(out_e_a), 32'h0);
    chk("t4_ovf_sticky", 32'(ovf_a), 32'h1);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t4_ovf_sticky2", 32'(ovf_a), 32'h1);

    // Synchronous-style reset to clear the sticky flag
    reset = 1'b1;
    @(negedge clk);
    chk("t4_ovf_cleared", 32'(ovf_a), 32'h0);
    reset = 1'b0;

    // Streaming 0..9, wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 5'(i), 1'b1);
      chk("t5_stream_e", 32'(out_e_a), 32'(i * 8));
      chk("t5_count_le1", 32'(count_a <= 3'd1), 32'h1);
    end
    cyc(1'b0, 5'd0, 1'b1);
    chk("t5_end_empty", 32'(out_valid_a), 32'h0);

    // Asynchronous reset mid-cycle discards stored codes
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'(20 + i), 1'b0);
    chk("t6_count3", 32'(count_a), 32'h3);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid_a), 32'h0);
    chk("t6_async_count", 32'(count_a), 32'h0);
    chk("t6_async_e", 32'(out_e_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 5'h0A, 1'b0);
    chk("t6_new_e", 32'(out_e_a), 32'h50);
    chk("t6_new_count", 32'(count_a), 32'h1);
    cyc(1'b0, 5'd0, 1'b1);
    chk("t6_final_empty", 32'(out_valid_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
